// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot-low column strobes, synchronized row returns, pass-based key detect.
// Define KEYPAD_DEBOUNCE_EN to build the DEBOUNCE/RELEASE states that require DEBOUNCE_CNT matching passes.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1) begin : g_bad_params
        $error("keypad_scanner: SCAN_DIV must be >= 4 and DEBOUNCE_CNT >= 1");
    end

    logic [3:0]    row_meta;
    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic          tc;
    logic          hit;
    logic [1:0]    row_idx;
    logic [3:0]    col_code;
    logic          acc_found;
    logic [3:0]    acc_code;
    logic          pass_done;
    logic          pass_found;
    logic [3:0]    pass_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_s    <= '1;
        end else begin
            row_meta <= row_n;
            row_s    <= row_meta;
        end
    end

    assign tc = (dwell == DW'(SCAN_DIV - 1));

    always_comb begin
        hit = ~&row_s;
        if (!row_s[0])      row_idx = 2'd0;
        else if (!row_s[1]) row_idx = 2'd1;
        else if (!row_s[2]) row_idx = 2'd2;
        else                row_idx = 2'd3;
        col_code = {col_idx, row_idx};
    end

    // Earlier columns keep priority: the accumulator only takes a hit while nothing is recorded yet.
    assign pass_done  = tc && (col_idx == 2'd3);
    assign pass_found = acc_found | hit;
    assign pass_code  = acc_found ? acc_code : col_code;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell     <= '0;
            col_idx   <= '0;
            col_n     <= 4'b1110;
            acc_found <= 1'b0;
            acc_code  <= '0;
        end else if (tc) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col_n   <= ~(4'b0001 << (col_idx + 2'd1));
            if (col_idx == 2'd0) begin
                acc_found <= hit;
                acc_code  <= col_code;
            end else if (!acc_found && hit) begin
                acc_found <= 1'b1;
                acc_code  <= col_code;
            end
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    candidate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            candidate <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (pass_done) begin
                case (state)
                    IDLE: if (pass_found) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state     <= PRESSED;
                            key_code  <= pass_code;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            candidate <= pass_code;
                            cnt       <= CW'(1);
                            state     <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (!pass_found) begin
                            state <= IDLE;
                        end else if (pass_code != candidate) begin
                            candidate <= pass_code;
                            cnt       <= CW'(1);
                        end else if (cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                            state     <= PRESSED;
                            key_code  <= candidate;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PRESSED: if (!pass_found) begin
                        if (DEBOUNCE_CNT == 1) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                        end else begin
                            cnt   <= CW'(1);
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (pass_found) begin
                            state <= PRESSED;
                        end else if (cnt + CW'(1) == CW'(DEBOUNCE_CNT)) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`else
    typedef enum logic [0:0] {IDLE, PRESSED} state_t;

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (pass_done) begin
                case (state)
                    IDLE: if (pass_found) begin
                        state     <= PRESSED;
                        key_code  <= pass_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end
                    PRESSED: if (!pass_found) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
`endif

endmodule
